// File: rtl/baud_pkg.sv
// Shared constants and helpers for the UART baud tick generator.
// Optional runtime divisor: define BAUD_RUNTIME_DIV_EN.
package baud_pkg;

    localparam int DEF_CLK_FREQ   = 50_000_000;
    localparam int DEF_BAUD_RATE  = 19_200;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int RT_DIV_W       = 16;

    function automatic int calc_div(
        input int clk_freq,
        input int baud,
        input int oversample
    );
        int d;
        d = baud * oversample;
        return (clk_freq + d / 2) / d;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DIV_W = cnt_w(calc_div(DEF_CLK_FREQ, DEF_BAUD_RATE,
                                          DEF_OVERSAMPLE));
    localparam int OS_W  = cnt_w(DEF_OVERSAMPLE);

endpackage

// File: rtl/baud_tick_counter.sv
// Mod-N counter with enable, synchronous clear and registered terminal pulse.
// wrap is the combinational terminal condition, used to chain stages.
module baud_tick_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] last,
    output logic         wrap,
    output logic         tick
);

    logic [W-1:0] cnt;

    assign wrap = en && !clr && (cnt == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt == last) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/baud_rate_generator.sv
// UART baud generator: oversample tick (out) and bit tick (bit_tick).
// Define BAUD_RUNTIME_DIV_EN to add a runtime-loadable divisor.
module baud_rate_generator
    import baud_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD_RATE  = DEF_BAUD_RATE,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DIV        = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
`ifdef BAUD_RUNTIME_DIV_EN
    input  logic        div_load,
    input  logic [15:0] div_value,
`endif
    output logic        out,
    output logic        bit_tick
);

    localparam int OSW = cnt_w(OVERSAMPLE);

    if (DIV < 2) begin : g_bad_div
        $error("baud_rate_generator: DIV must be >= 2");
    end
    if (OVERSAMPLE < 1) begin : g_bad_os
        $error("baud_rate_generator: OVERSAMPLE must be >= 1");
    end

`ifdef BAUD_RUNTIME_DIV_EN
    localparam int DW = RT_DIV_W;

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_last;
    logic          clr;

    // Loading restarts the phase so no partial period is emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= DW'(DIV);
        end else if (div_load) begin
            div_q <= (div_value < 16'd2) ? 16'd2 : div_value;
        end
    end

    assign div_last = div_q - 1'b1;
    assign clr      = div_load || !enable;
`else
    localparam int DW = cnt_w(DIV);

    logic [DW-1:0] div_last;
    logic          clr;

    assign div_last = DW'(DIV - 1);
    assign clr      = !enable;
`endif

    logic div_wrap;
    logic os_wrap_unused;

    baud_tick_counter #(
        .W (DW)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (enable),
        .clr   (clr),
        .last  (div_last),
        .wrap  (div_wrap),
        .tick  (out)
    );

    baud_tick_counter #(
        .W (OSW)
    ) u_os (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (div_wrap),
        .clr   (clr),
        .last  (OSW'(OVERSAMPLE - 1)),
        .wrap  (os_wrap_unused),
        .tick  (bit_tick)
    );

endmodule

// File: tb/tb_baud_rate_generator.sv
// Directed bench for baud_rate_generator (DIV=10/OS=16 and DIV=2/OS=1).
// Exercises BAUD_RUNTIME_DIV_EN when that macro is defined.
module tb_baud_rate_generator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic out, bit_tick;
    logic out2, bit2;

    int checks = 0;
    int errors = 0;
    int k1 = 0;
    int k2 = 0;
    int d1 = 10;

`ifdef BAUD_RUNTIME_DIV_EN
    logic        div_load = 1'b0;
    logic [15:0] div_value = 16'd0;
    logic        div_load2 = 1'b0;
    logic [15:0] div_value2 = 16'd0;
`endif

    always #5 clk = ~clk;

    baud_rate_generator #(
        .CLK_FREQ   (1_600_000),
        .BAUD_RATE  (10_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
`ifdef BAUD_RUNTIME_DIV_EN
        .div_load  (div_load),
        .div_value (div_value),
`endif
        .out       (out),
        .bit_tick  (bit_tick)
    );

    baud_rate_generator #(
        .CLK_FREQ   (20_000),
        .BAUD_RATE  (10_000),
        .OVERSAMPLE (1)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
`ifdef BAUD_RUNTIME_DIV_EN
        .div_load  (div_load2),
        .div_value (div_value2),
`endif
        .out       (out2),
        .bit_tick  (bit2)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        logic ld;
        ld = 1'b0;
        @(posedge clk);
`ifdef BAUD_RUNTIME_DIV_EN
        ld = div_load;
`endif
        if (!rst_n) begin
            k1 = 0;
            k2 = 0;
            d1 = 10;
        end else begin
            if (ld) begin
`ifdef BAUD_RUNTIME_DIV_EN
                k1 = 0;
                d1 = (div_value < 16'd2) ? 2 : int'(div_value);
`endif
            end else if (!enable) begin
                k1 = 0;
            end else begin
                k1++;
            end
            k2 = enable ? k2 + 1 : 0;
        end
        #1;
        check("out", out, k1 != 0 && k1 % d1 == 0);
        check("bit_tick", bit_tick, k1 != 0 && k1 % (d1 * 16) == 0);
        check("out2", out2, k2 != 0 && k2 % 2 == 0);
        check("bit2", bit2, k2 != 0 && k2 % 2 == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out", out, 1'b0);
        check("async_bit", bit_tick, 1'b0);
        check("async_out2", out2, 1'b0);
        k1 = 0;
        k2 = 0;
        d1 = 10;
        run(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b1;
        #1;
        check("rst_out", out, 1'b0);
        check("rst_bit", bit_tick, 1'b0);
        run(5);
        rst_n = 1'b1;

        run(330);

        // Reset while both ticks are high must clear them without a clock.
        async_reset();
        run(160);
        check("pre_async_bit", bit_tick, 1'b1);
        async_reset();

        run(25);
        enable = 1'b0;
        run(7);
        enable = 1'b1;
        run(170);

        async_reset();
        run(6);
        async_reset();
        run(12);

`ifdef BAUD_RUNTIME_DIV_EN
        div_load = 1'b1;
        div_value = 16'd4;
        tick();
        div_load = 1'b0;
        run(140);
        div_load = 1'b1;
        div_value = 16'd1;
        enable = 1'b0;
        tick();
        div_load = 1'b0;
        enable = 1'b1;
        run(40);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
